// File: rtl/mem_byte_bridge.sv
// Purpose : byte-wide bridge to a WORD_W simple dual-port memory; packs loader bytes into words, streams burst words back out as bytes.
// Latency : last loader byte at T -> mem_we at T+1; rd_start at T -> mem_re T+1, first out_valid T+3, 2-cycle bubble between burst words.
// Backpressure: out_ready low stalls the readout with out_byte/out_last held; the loader channel has no backpressure (1 byte/cycle).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ld_valid, ld_byte             loader byte strobe and data (little-endian packing)
//   ld_addr_load, ld_addr_in      write-pointer load (discards any partial word)
//   mem_we, mem_waddr, mem_wdata  memory write port (one-cycle pulse per word)
//   rd_start, rd_addr, rd_len     burst request: first address, word count minus one
//   mem_re, mem_raddr, mem_rdata  memory read port (data valid the cycle after mem_re)
//   out_byte, out_valid, out_ready, out_last  byte stream with valid/ready handshake
//   rd_busy, rd_done              readout activity flag and end-of-burst pulse
module mem_byte_bridge #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 7,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_addr_load,
    input  logic [ADDR_W-1:0] ld_addr_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_len,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              rd_busy,
    output logic              rd_done
);
    localparam int NB = WORD_W / 8;
    localparam int BW = $clog2(NB);
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    // ---------------------------------------------------------------
    // Loader channel
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] wptr;
    logic [BW-1:0]     cnt;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] asm_next;

    // Word as it looks once the current byte is merged in; on the final
    // byte this is exactly the word to write.
    always_comb begin
        asm_next = asm_word;
        asm_next[8*cnt +: 8] = ld_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            cnt       <= '0;
            asm_word  <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            // Pointer load wins over a same-cycle byte, which is dropped.
            if (ld_addr_load) begin
                wptr <= ld_addr_in;
                cnt  <= '0;
            end else if (ld_valid) begin
                asm_word <= asm_next;
                if (cnt == LAST_IDX) begin
                    mem_we    <= 1'b1;
                    mem_waddr <= wptr;
                    mem_wdata <= asm_next;
                    cnt       <= '0;
                    wptr      <= wptr + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Readout channel
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPT,
        SEND
    } rd_state_t;

    rd_state_t         state;
    logic [ADDR_W-1:0] rptr;
    logic [7:0]        words_left;
    logic [BW-1:0]     bidx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_adv;

    // The byte on the wire always sits at the same end of the shift
    // register, so out_byte is a plain register slice and holds while stalled.
    assign shreg_adv = MSB_FIRST ? (shreg << 8) : (shreg >> 8);
    assign out_byte  = MSB_FIRST ? shreg[WORD_W-1 -: 8] : shreg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rptr       <= '0;
            words_left <= '0;
            bidx       <= '0;
            shreg      <= '0;
            mem_re     <= 1'b0;
            mem_raddr  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            rd_busy    <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        rptr       <= rd_addr;
                        words_left <= rd_len;
                        mem_re     <= 1'b1;
                        mem_raddr  <= rd_addr;
                        rd_busy    <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // mem_re was raised on entry; the read is issued now.
                    mem_re <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    shreg     <= mem_rdata;
                    bidx      <= '0;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (bidx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (words_left == 8'd0) begin
                                rd_done <= 1'b1;
                                rd_busy <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                words_left <= words_left - 8'd1;
                                rptr       <= rptr + 1'b1;
                                mem_re     <= 1'b1;
                                mem_raddr  <= rptr + 1'b1;
                                state      <= FETCH;
                            end
                        end else begin
                            bidx     <= bidx + 1'b1;
                            shreg    <= shreg_adv;
                            // Flag the byte about to be presented if it closes the burst.
                            out_last <= (words_left == 8'd0) && (bidx == LAST_IDX - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_bridge.sv
module tb_mem_byte_bridge;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ld_valid = 1'b0, ld_addr_load = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic [6:0]  ld_addr_in = '0;
    logic        mem_we, mem_re;
    logic [6:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        rd_start = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [7:0]  rd_len = '0;
    logic [7:0]  out_byte;
    logic        out_valid, out_last, rd_busy, rd_done;
    logic        out_ready = 1'b0;

    // Second instance with MSB_FIRST=1, sharing the readout stimulus.
    logic        z_valid = 1'b0, z_load = 1'b0;
    logic [7:0]  z_byte = '0;
    logic [6:0]  z_addr = '0;
    logic        m_we, m_re, m_valid, m_last, m_busy, m_done;
    logic [6:0]  m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rdata;
    logic [7:0]  m_byte;

    mem_byte_bridge #(.WORD_W(32), .ADDR_W(7), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_addr_load(ld_addr_load), .ld_addr_in(ld_addr_in),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .rd_busy(rd_busy), .rd_done(rd_done)
    );

    mem_byte_bridge #(.WORD_W(32), .ADDR_W(7), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst),
        .ld_valid(z_valid), .ld_byte(z_byte), .ld_addr_load(z_load), .ld_addr_in(z_addr),
        .mem_we(m_we), .mem_waddr(m_waddr), .mem_wdata(m_wdata),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
        .mem_re(m_re), .mem_raddr(m_raddr), .mem_rdata(m_rdata),
        .out_byte(m_byte), .out_valid(m_valid), .out_ready(out_ready), .out_last(m_last),
        .rd_busy(m_busy), .rd_done(m_done)
    );

    // Memory: synchronous read, writes from the DUT loader or a bench preload.
    logic [31:0] mem [128];
    logic        pl_we = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (pl_we)  mem[pl_addr]   <= pl_data;
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (m_re)   m_rdata   <= mem[m_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, passes = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [6:0] a; logic [31:0] d; int c; } wr_t;
    typedef struct { logic [7:0] byt; logic lst; } rb_t;
    wr_t        exp_wr[$];
    wr_t        wr_log[$];
    rb_t        exp_rd[$];
    logic [6:0] exp_ra[$];
    logic [6:0] m_wptr = '0;
    logic [7:0] m_bytes[$];
    bit         en = 1'b0;

    task automatic ld_ptr(input logic [6:0] a, input logic with_byte, input logic [7:0] b);
        ld_addr_load = 1'b1; ld_addr_in = a; ld_valid = with_byte; ld_byte = b;
        m_wptr = a;
        m_bytes.delete();
        step();
        ld_addr_load = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic ld_b(input logic [7:0] b);
        logic [31:0] w;
        ld_valid = 1'b1; ld_byte = b;
        m_bytes.push_back(b);
        if (m_bytes.size() == NB) begin
            w = '0;
            for (int i = 0; i < NB; i++) w[8*i +: 8] = m_bytes[i];
            exp_wr.push_back('{a: m_wptr, d: w, c: cyc + 1});
            m_wptr = m_wptr + 7'd1;
            m_bytes.delete();
        end
        step();
        ld_valid = 1'b0;
    endtask

    task automatic poke(input logic [6:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    // Queues the whole expected burst as bytes, then issues rd_start.
    task automatic start_rd(input logic [6:0] a, input logic [7:0] len);
        logic [6:0]  wa;
        logic [31:0] word;
        for (int w = 0; w <= int'(len); w++) begin
            wa   = a + 7'(w);
            word = mem[wa];
            exp_ra.push_back(wa);
            for (int b = 0; b < NB; b++)
                exp_rd.push_back('{byt: word[8*b +: 8], lst: (w == int'(len)) && (b == NB - 1)});
        end
        rd_addr = a; rd_len = len; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    // ---------------- per-cycle comparison against the model ----------------
    logic       stall_q = 1'b0, last_q = 1'b0;
    logic [7:0] byte_q = '0;
    always @(negedge clk) begin
        if (en) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("unexpected_mem_we", 1, 0);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("mem_waddr", mem_waddr, e.a);
                    chk("mem_wdata", mem_wdata, e.d);
                    chk("mem_we_cycle", cyc, e.c);
                end
                wr_log.push_back('{a: mem_waddr, d: mem_wdata, c: cyc});
            end
            if (mem_re) begin
                if (exp_ra.size() == 0) chk("unexpected_mem_re", 1, 0);
                else chk("mem_raddr", mem_raddr, exp_ra.pop_front());
            end
            if (stall_q) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_byte", out_byte, byte_q);
                chk("stall_last", out_last, last_q);
            end
            if (out_valid && out_ready) begin
                if (exp_rd.size() == 0) chk("extra_byte", 1, 0);
                else begin
                    rb_t r;
                    r = exp_rd.pop_front();
                    chk("out_byte", out_byte, r.byt);
                    chk("out_last", out_last, r.lst);
                end
            end
            if (rd_done) begin
                chk("done_busy", rd_busy, 0);
                chk("done_pending_bytes", exp_rd.size(), 0);
            end
            stall_q = out_valid && !out_ready;
            byte_q  = out_byte;
            last_q  = out_last;
        end
    end

    // Scenario 3: hand-computed cycle-by-cycle single-word read.
    task automatic single_read(input string tag);
        logic [7:0] le[4];
        logic [7:0] me[4];
        le = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        me = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        out_ready = 1'b1;
        start_rd(7'd3, 8'd0);
        chk({tag, "_re_t1"}, mem_re, 1);
        chk({tag, "_raddr_t1"}, mem_raddr, 7'd3);
        chk({tag, "_busy_t1"}, rd_busy, 1);
        step();
        chk({tag, "_valid_t2"}, out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_lsb_byte"}, out_byte, le[i]);
            chk({tag, "_last"}, out_last, (i == 3));
            chk({tag, "_msb_byte"}, m_byte, me[i]);
        end
        step();
        chk({tag, "_done_t7"}, rd_done, 1);
        chk({tag, "_busy_t7"}, rd_busy, 0);
        chk({tag, "_valid_t7"}, out_valid, 0);
        step();
        chk({tag, "_done_t8"}, rd_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        logic       lasts[$];
        logic [6:0] re_addrs[$];
        bit         done_seen;
        int         n;

        // Reset
        step(); step(); step();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        en  = 1'b1;
        step();

        // Scenario 1: pointer load and two words
        wr_log.delete();
        ld_ptr(7'd5, 1'b0, 8'h00);
        ld_b(8'h11); ld_b(8'h22); ld_b(8'h33); ld_b(8'h44);
        ld_b(8'h55); ld_b(8'h66); ld_b(8'h77); ld_b(8'h88);
        step(); step();
        chk("s1_writes", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            chk("s1_w0_addr", wr_log[0].a, 7'd5);
            chk("s1_w0_data", wr_log[0].d, 32'h44332211);
            chk("s1_w1_addr", wr_log[1].a, 7'd6);
            chk("s1_w1_data", wr_log[1].d, 32'h88776655);
            chk("s1_spacing", wr_log[1].c - wr_log[0].c, 4);
        end

        // Scenario 2: discard partial word, dropped same-cycle byte, wrap
        wr_log.delete();
        ld_b(8'h01); ld_b(8'h02);
        ld_ptr(7'h7F, 1'b1, 8'hEE);
        ld_b(8'hAA); ld_b(8'hBB); ld_b(8'hCC); ld_b(8'hDD);
        ld_b(8'h10); ld_b(8'h20); ld_b(8'h30); ld_b(8'h40);
        step(); step();
        chk("s2_writes", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            chk("s2_w0_addr", wr_log[0].a, 7'h7F);
            chk("s2_w0_data", wr_log[0].d, 32'hDDCCBBAA);
            chk("s2_w1_addr", wr_log[1].a, 7'h00);
            chk("s2_w1_data", wr_log[1].d, 32'h40302010);
        end

        // Scenario 3: single-word read (both byte orders)
        poke(7'd3, 32'hDEADBEEF);
        step();
        single_read("s3");

        // Scenario 4: burst across the address wrap with backpressure
        poke(7'h7F, 32'h04030201);
        poke(7'h00, 32'h08070605);
        step();
        out_ready = 1'b0;
        start_rd(7'h7F, 8'd1);
        done_seen = 1'b0;
        n = 0;
        while (!done_seen && n < 200) begin
            out_ready = ~out_ready;
            if (mem_re) re_addrs.push_back(mem_raddr);
            if (out_valid && out_ready) begin
                got.push_back(out_byte);
                lasts.push_back(out_last);
            end
            if (rd_done) done_seen = 1'b1;
            step();
            n++;
        end
        chk("s4_completed", done_seen, 1);
        chk("s4_byte_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) begin
            chk("s4_byte_order", got[i], 8'(i + 1));
            chk("s4_last_only_final", lasts[i], (i == 7));
        end
        chk("s4_fetch_count", re_addrs.size(), 2);
        if (re_addrs.size() >= 2) chk("s4_second_raddr", re_addrs[1], 7'h00);

        // Scenario 5: ignored rd_start while busy, reset mid-burst, fresh read
        out_ready = 1'b1;
        step();
        start_rd(7'h7F, 8'd1);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("s5_stream_started", out_valid, 1);
        step();
        rd_addr = 7'd3; rd_len = 8'd0; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("s5_busy_after_ignored", rd_busy, 1);
        step();
        rst = 1'b1;
        step();
        chk("s5_rst_valid", out_valid, 0);
        chk("s5_rst_busy", rd_busy, 0);
        chk("s5_rst_mem_we", mem_we, 0);
        chk("s5_rst_mem_re", mem_re, 0);
        exp_rd.delete();
        exp_ra.delete();
        rst = 1'b0;
        step();
        single_read("s5");

        step(); step();
        chk("end_writes_drained", exp_wr.size(), 0);
        chk("end_bytes_drained", exp_rd.size(), 0);
        chk("end_fetches_drained", exp_ra.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
